// File: rtl/count_ctrl_pkg.sv
// Shared definitions for the run-control front end of the 0-9999 BCD counter.
// Holds state encodings, default timing parameters and the short simulation values.
package count_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10
    } state_e;

    localparam int unsigned DEBOUNCE_CYCLES_DEF = 32'd80000;    // 20 ms @ 4 MHz
    localparam int unsigned TICK_DIV_DEF        = 32'd4000000;  // 1 Hz  @ 4 MHz

    localparam int unsigned SIM_DEBOUNCE_CYCLES = 32'd4;
    localparam int unsigned SIM_TICK_DIV        = 32'd10;

    // Bits needed to hold counts 0..n-1, never less than one.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 32'd2) ? 32'd1 : 32'($clog2(n));
    endfunction

endpackage

// File: rtl/count_ctrl_if.sv
// Panel-button inputs and count strobes exchanged between count_ctrl and the digit counter.
interface count_ctrl_if;
    import count_ctrl_pkg::*;

    logic   btn_start;
    logic   btn_clear;
    logic   cnt_inc;
    logic   cnt_clr;
    logic   running;
    state_e state;

    modport master (
        input  btn_start,
        input  btn_clear,
        output cnt_inc,
        output cnt_clr,
        output running,
        output state
    );

    modport slave (
        output btn_start,
        output btn_clear,
        input  cnt_inc,
        input  cnt_clr,
        input  running,
        input  state
    );

endinterface

// File: rtl/count_ctrl_btn_debounce.sv
// One pushbutton: 2-flop synchronizer, stability-count debouncer and registered press pulse.
module count_ctrl_btn_debounce
    import count_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    localparam int unsigned           CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 32'd1);

    logic             sync1;
    logic             sync2;
    logic             level;
    logic             level_q;
    logic [CNT_W-1:0] stab_cnt;

    // Synchronizer and rising-edge pulse on the accepted level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level_q <= 1'b0;
            press   <= 1'b0;
        end else begin
            sync1   <= btn;
            sync2   <= sync1;
            level_q <= level;
            press   <= level & ~level_q;
        end
    end

    // Level is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level    <= 1'b0;
            stab_cnt <= '0;
        end else if (sync2 == level) begin
            stab_cnt <= '0;
        end else if (stab_cnt == CNT_LAST) begin
            level    <= sync2;
            stab_cnt <= '0;
        end else begin
            stab_cnt <= stab_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/count_ctrl.sv
// Run-control front end: debounced start/stop and clear buttons drive an IDLE/RUN/PAUSE
// machine that emits single-cycle increment and clear strobes for the BCD digit counter.
module count_ctrl
    import count_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned TICK_DIV        = TICK_DIV_DEF
) (
    input  logic         clk,
    input  logic         rst,
    count_ctrl_if.master bus
);

    localparam int unsigned      PRE_W    = cnt_width(TICK_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 32'd1);

    logic             start_press;
    logic             clear_press;
    state_e           state_q;
    state_e           state_d;
    logic [PRE_W-1:0] presc_q;
    logic [PRE_W-1:0] presc_d;
    logic             inc_d;
    logic             clr_d;
    logic             cnt_inc_q;
    logic             cnt_clr_q;
    logic             running_q;

    count_ctrl_btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db_start (
        .clk   (clk),
        .rst   (rst),
        .btn   (bus.btn_start),
        .press (start_press)
    );

    count_ctrl_btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db_clear (
        .clk   (clk),
        .rst   (rst),
        .btn   (bus.btn_clear),
        .press (clear_press)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, prescaler and strobes; clear always overrides a simultaneous start.
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        inc_d   = 1'b0;
        clr_d   = 1'b0;

        if (clear_press) begin
            state_d = ST_IDLE;
            clr_d   = 1'b1;
        end else if (start_press) begin
            case (state_q)
                ST_IDLE:  state_d = ST_RUN;
                ST_RUN:   state_d = ST_PAUSE;
                ST_PAUSE: state_d = ST_RUN;
                default:  state_d = ST_IDLE;
            endcase
        end

        // A wrap on the cycle RUN is left produces no strobe.
        case (state_q)
            ST_RUN: begin
                if (presc_q == PRE_LAST) begin
                    presc_d = '0;
                    inc_d   = (state_d == ST_RUN);
                end else begin
                    presc_d = presc_q + PRE_W'(1);
                end
            end
            ST_PAUSE: presc_d = presc_q;
            default:  presc_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q   <= '0;
            cnt_inc_q <= 1'b0;
            cnt_clr_q <= 1'b0;
            running_q <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            cnt_inc_q <= inc_d;
            cnt_clr_q <= clr_d;
            running_q <= (state_d == ST_RUN);
        end
    end

    assign bus.cnt_inc = cnt_inc_q;
    assign bus.cnt_clr = cnt_clr_q;
    assign bus.running = running_q;
    assign bus.state   = state_q;

endmodule

// File: tb/tb_count_ctrl.sv
// Bench for count_ctrl: directed scenarios plus randomized button traffic against a
// cycle-stepped behavioural model built from sample-window and run-time arithmetic.
module tb_count_ctrl;
    import count_ctrl_pkg::*;

    localparam int unsigned DB = SIM_DEBOUNCE_CYCLES;
    localparam int unsigned TD = SIM_TICK_DIV;

    logic clk;
    logic rst;

    count_ctrl_if bus ();

    count_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .TICK_DIV       (TD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: raw sample history, accepted levels, state number and RUN time.
    logic [63:0] m_hist [2];
    logic        m_deb  [2];
    logic        m_rose [2];
    logic        m_pv   [2];
    int          m_st;
    int          m_runc;
    logic        m_inc;
    logic        m_clr;

    function automatic void model_reset();
        for (int b = 0; b < 2; b++) begin
            m_hist[b] = '0;
            m_deb[b]  = 1'b0;
            m_rose[b] = 1'b0;
            m_pv[b]   = 1'b0;
        end
        m_st   = 0;
        m_runc = 0;
        m_inc  = 1'b0;
        m_clr  = 1'b0;
    endfunction

    function automatic void model_step(input logic bs, input logic bc);
        logic        raw [2];
        logic [63:0] mask;
        logic [63:0] win;
        int          old_st;
        int          nxt;
        raw[0] = bs;
        raw[1] = bc;
        mask   = (64'd1 << DB) - 64'd1;
        old_st = m_st;
        nxt    = m_st;
        m_clr  = 1'b0;
        m_inc  = 1'b0;
        if (m_pv[1]) begin
            nxt   = 0;
            m_clr = 1'b1;
        end else if (m_pv[0]) begin
            nxt = (old_st == 1) ? 2 : 1;
        end
        // Strobe every TD cycles of accumulated RUN time, only if RUN continues.
        if (old_st == 1) begin
            m_runc++;
            m_inc = ((m_runc % TD) == 0) && (nxt == 1);
        end else if (old_st == 0) begin
            m_runc = 0;
        end
        m_st = nxt;
        for (int b = 0; b < 2; b++) begin
            m_pv[b]   = m_rose[b];
            m_hist[b] = {m_hist[b][62:0], raw[b]};
            win       = (m_hist[b] >> 2) & mask;
            m_rose[b] = 1'b0;
            if (!m_deb[b] && (win == mask)) begin
                m_deb[b]  = 1'b1;
                m_rose[b] = 1'b1;
            end else if (m_deb[b] && (win == 64'd0)) begin
                m_deb[b] = 1'b0;
            end
        end
    endfunction

    int cyc        = 0;
    int inc_seen   = 0;
    int clr_seen   = 0;
    int pause_seen = 0;
    int trans      = 0;
    int run_entry  = -1;
    int prev_st    = 0;

    task automatic cycle(input logic bs, input logic bc);
        int st;
        @(negedge clk);
        bus.btn_start = bs;
        bus.btn_clear = bc;
        @(posedge clk);
        model_step(bs, bc);
        #1;
        check_eq("state",   32'(bus.state), 32'(m_st));
        check_eq("running", 32'(bus.running), 32'(m_st == 1));
        check_eq("cnt_inc", 32'(bus.cnt_inc), 32'(m_inc));
        check_eq("cnt_clr", 32'(bus.cnt_clr), 32'(m_clr));
        check_eq("inc_clr_excl", 32'(bus.cnt_inc & bus.cnt_clr), 32'd0);
        cyc++;
        st = int'(bus.state);
        if (bus.cnt_inc) inc_seen++;
        if (bus.cnt_clr) clr_seen++;
        if (st == 2) pause_seen++;
        if (st != prev_st) begin
            trans++;
            if (st == 1) run_entry = cyc;
        end
        prev_st = st;
    endtask

    task automatic apply_reset(input logic bs, input logic bc);
        @(negedge clk);
        #2;
        rst           = 1'b0;
        bus.btn_start = bs;
        bus.btn_clear = bc;
        #1;
        check_eq("rst_state",   32'(bus.state), 32'd0);
        check_eq("rst_running", 32'(bus.running), 32'd0);
        check_eq("rst_cnt_inc", 32'(bus.cnt_inc), 32'd0);
        check_eq("rst_cnt_clr", 32'(bus.cnt_clr), 32'd0);
        model_reset();
        prev_st = 0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0);
    endtask

    task automatic hold(input logic bs, input logic bc, input int n);
        for (int i = 0; i < n; i++) cycle(bs, bc);
    endtask

    // Bounded wait for the next increment strobe.
    task automatic wait_inc(input string tag);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 4 * TD && !found; i++) begin
            cycle(1'b0, 1'b0);
            found = bus.cnt_inc;
        end
        check_eq(tag, 32'(found), 32'd1);
    endtask

    initial begin
        int c0;
        int got;
        rst           = 1'b1;
        bus.btn_start = 1'b0;
        bus.btn_clear = 1'b0;
        apply_reset(1'b0, 1'b0);
        idle(5);

        // Clean start press: RUN DB+4 edges after the first sampled high, then TD-period strobes.
        c0 = cyc;
        hold(1'b1, 1'b0, 10);
        check_eq("start_latency", 32'(run_entry - c0), 32'(DB + 4));
        inc_seen = 0;
        got      = -1;
        for (int i = 0; i < 48; i++) begin
            cycle(1'b0, 1'b0);
            if (bus.cnt_inc && got < 0) got = cyc - run_entry;
        end
        check_eq("first_inc_delay", 32'(got), 32'(TD));
        check_eq("inc_count_50", 32'(inc_seen), 32'd5);

        // Pause six cycles into a period, sit 40 cycles, resume.
        wait_inc("wait_inc_pre_pause");
        idle(8);
        hold(1'b1, 1'b0, 6);
        inc_seen = 0;
        idle(40);
        check_eq("paused_state", 32'(bus.state), 32'd2);
        check_eq("paused_no_inc", 32'(inc_seen), 32'd0);
        hold(1'b1, 1'b0, 6);
        got = -1;
        for (int i = 0; i < 30 && got < 0; i++) begin
            cycle(1'b0, 1'b0);
            if (bus.cnt_inc) got = cyc - run_entry;
        end
        check_eq("resume_gap", 32'(got), 32'(TD - 6));

        // Start and clear together while running: clear wins.
        clr_seen = 0; pause_seen = 0; inc_seen = 0;
        hold(1'b1, 1'b1, 6);
        idle(15);
        check_eq("both_clr_count", 32'(clr_seen), 32'd1);
        check_eq("both_no_pause", 32'(pause_seen), 32'd0);
        check_eq("both_no_inc", 32'(inc_seen), 32'd0);
        check_eq("both_state", 32'(bus.state), 32'd0);

        // Clear in IDLE.
        clr_seen = 0; trans = 0;
        hold(1'b0, 1'b1, 6);
        idle(10);
        check_eq("idle_clr_count", 32'(clr_seen), 32'd1);
        check_eq("idle_clr_trans", 32'(trans), 32'd0);

        // RUN for exactly one period then PAUSE (wrap on exit), then clear from PAUSE.
        inc_seen = 0;
        hold(1'b1, 1'b0, 6); idle(4);
        hold(1'b1, 1'b0, 6); idle(4);
        check_eq("to_pause_state", 32'(bus.state), 32'd2);
        check_eq("exit_wrap_no_inc", 32'(inc_seen), 32'd0);
        clr_seen = 0;
        hold(1'b0, 1'b1, 6); idle(4);
        check_eq("pause_clr_count", 32'(clr_seen), 32'd1);
        check_eq("pause_clr_state", 32'(bus.state), 32'd0);

        // Bounce then hold: one transition. A short glitch: none.
        trans = 0;
        hold(1'b1, 1'b0, 2); idle(2);
        hold(1'b1, 1'b0, 2); idle(2);
        hold(1'b1, 1'b0, 8); idle(10);
        check_eq("bounce_trans", 32'(trans), 32'd1);
        trans = 0;
        hold(1'b1, 1'b0, 3); idle(12);
        check_eq("glitch_trans", 32'(trans), 32'd0);

        // Reset mid-run, then quiet for 100 cycles.
        apply_reset(1'b0, 1'b0);
        inc_seen = 0; clr_seen = 0; trans = 0;
        idle(100);
        check_eq("post_rst_trans", 32'(trans), 32'd0);
        check_eq("post_rst_inc", 32'(inc_seen), 32'd0);
        check_eq("post_rst_clr", 32'(clr_seen), 32'd0);

        // Button held across reset release: exactly one press.
        apply_reset(1'b1, 1'b0);
        trans = 0;
        c0    = cyc;
        hold(1'b1, 1'b0, 10); idle(5);
        check_eq("held_rst_trans", 32'(trans), 32'd1);
        check_eq("held_rst_latency", 32'(run_entry - c0), 32'(DB + 4));

        // Random button traffic with occasional resets.
        for (int seg = 0; seg < 250; seg++) begin
            logic bs;
            logic bc;
            int   len;
            len = int'($urandom_range(1, 12));
            bs  = ($urandom_range(0, 2) == 0);
            bc  = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 59) == 0) apply_reset(bs, bc);
            hold(bs, bc, len);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
